// File: rtl/calc_seq_core.sv
// Sequenced calculator core: operand/function latch, IDLE/EXEC/DONE control FSM and an
// iterative shift-add multiplier / restoring divider sharing one pair of working registers.
module calc_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       fct_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] r_o,
    output logic             carry_o,
    output logic             err_o,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] FCT_ADD = 2'b00;
    localparam logic [1:0] FCT_SUB = 2'b01;
    localparam logic [1:0] FCT_MUL = 2'b10;
    localparam logic [1:0] FCT_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Handshake: an operation is accepted on a rising edge where start_i=1 and ready_o=1;
    // results are valid from the cycle done_o is high and hold until the next DONE entry.

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_fct;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic             r_carry;
    logic             r_err;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_div0;
    logic             w_iter;
    logic             w_last_step;
    logic             w_finish;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_tsub;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;

    assign w_is_mul    = (r_fct == FCT_MUL);
    assign w_is_div    = (r_fct == FCT_DIV);
    assign w_div0      = w_is_div && (r_b == '0);
    assign w_iter      = (w_is_mul || w_is_div) && !w_div0;
    assign w_last_step = (r_cnt == CW'(WIDTH - 1));
    assign w_finish    = !w_iter || w_last_step;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Multiply: r_hi accumulates, r_lo shifts the multiplier out and the product low half in.
    assign w_madd   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_a}) : {1'b0, r_hi};
    assign w_mul_hi = w_madd[WIDTH:1];
    assign w_mul_lo = {w_madd[0], r_lo[WIDTH-1:1]};

    // Divide: r_hi is the partial remainder, r_lo shifts the dividend out and quotient bits in.
    assign w_trial  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = (w_trial >= {1'b0, r_b});
    assign w_tsub   = w_trial[WIDTH-1:0] - r_b;
    assign w_div_hi = w_ge ? w_tsub : w_trial[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    assign w_step_hi = w_is_mul ? w_mul_hi : w_div_hi;
    assign w_step_lo = w_is_mul ? w_mul_lo : w_div_lo;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nx = start_i ? S_EXEC : S_IDLE;
            S_EXEC:  w_state_nx = w_finish ? S_DONE : S_EXEC;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_fct   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_s     <= '0;
            r_r     <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start_i) begin
                r_a   <= a_i;
                r_b   <= b_i;
                r_fct <= fct_i;
                r_cnt <= '0;
                r_hi  <= '0;
                r_lo  <= (fct_i == FCT_MUL) ? b_i : a_i;
            end
        end else if (r_state == S_EXEC) begin
            if (!w_iter) begin
                if (r_fct == FCT_ADD) begin
                    r_s     <= w_sum[WIDTH-1:0];
                    r_r     <= '0;
                    r_carry <= w_sum[WIDTH];
                    r_err   <= 1'b0;
                end else if (r_fct == FCT_SUB) begin
                    r_s     <= w_diff[WIDTH-1:0];
                    r_r     <= '0;
                    r_carry <= w_diff[WIDTH];
                    r_err   <= 1'b0;
                end else begin
                    r_s     <= '1;
                    r_r     <= r_a;
                    r_carry <= 1'b0;
                    r_err   <= 1'b1;
                end
            end else begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + CW'(1);
                if (w_last_step) begin
                    r_s     <= w_step_lo;
                    r_r     <= w_step_hi;
                    r_carry <= w_is_mul && (w_step_hi != '0);
                    r_err   <= 1'b0;
                end
            end
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign busy_o      = (r_state == S_EXEC) || (r_state == S_DONE);
    assign done_o      = (r_state == S_DONE);
    assign s_o         = r_s;
    assign r_o         = r_r;
    assign carry_o     = r_carry;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_calc_seq_core.sv
// Directed bench for calc_seq_core at WIDTH=8: results, flags, latency, ignored starts, reset abort.
module tb_calc_seq_core;

    localparam int W = 8;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [1:0]   fct_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] s_o;
    logic [W-1:0] r_o;
    logic         carry_o;
    logic         err_o;
    logic [1:0]   dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    calc_seq_core #(.WIDTH(W)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .fct_i       (fct_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .s_o         (s_o),
        .r_o         (r_o),
        .carry_o     (carry_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ends at the negedge of the first EXEC cycle.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
        @(negedge clock_i);
        a_i     = a;
        b_i     = b;
        fct_i   = f;
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
    endtask

    // Counts cycles from the first EXEC cycle until done_o, bounded.
    task automatic wait_done(input int start_cnt, output int cyc);
        cyc = start_cnt;
        while (done_o !== 1'b1 && cyc < 40) begin
            @(negedge clock_i);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] f, input int lat, input logic [W-1:0] es,
                          input logic [W-1:0] er, input logic ec, input logic ee);
        int cyc;
        start_op(a, b, f);
        check({tag, "_busy"}, busy_o, 1);
        check({tag, "_notready"}, ready_o, 0);
        wait_done(0, cyc);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_s"}, s_o, es);
        check({tag, "_r"}, r_o, er);
        check({tag, "_carry"}, carry_o, ec);
        check({tag, "_err"}, err_o, ee);
        @(negedge clock_i);
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_ready_back"}, ready_o, 1);
    endtask

    initial begin
        int cyc;
        int seen;

        // Reset held with start asserted: reset must win.
        reset_i = 1'b1;
        start_i = 1'b1;
        a_i     = 8'd5;
        b_i     = 8'd3;
        fct_i   = 2'b00;
        repeat (3) @(negedge clock_i);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_s", s_o, 0);
        check("rst_r", r_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_err", err_o, 0);
        check("rst_state", dbg_state_o, 0);
        start_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clock_i);

        run_op("add",      8'd200, 8'd100, 2'b00, 1, 8'd44,  8'd0,   1'b1, 1'b0);
        run_op("sub_lt",   8'd5,   8'd9,   2'b01, 1, 8'd252, 8'd0,   1'b1, 1'b0);
        run_op("sub_gt",   8'd9,   8'd5,   2'b01, 1, 8'd4,   8'd0,   1'b0, 1'b0);
        run_op("mul",      8'd25,  8'd13,  2'b10, W, 8'd69,  8'd1,   1'b1, 1'b0);
        run_op("mul_max",  8'd255, 8'd255, 2'b10, W, 8'd1,   8'd254, 1'b1, 1'b0);
        run_op("div",      8'd100, 8'd7,   2'b11, W, 8'd14,  8'd2,   1'b0, 1'b0);
        run_op("div0",     8'd77,  8'd0,   2'b11, 1, 8'd255, 8'd77,  1'b0, 1'b1);
        run_op("add_wrap", 8'd255, 8'd1,   2'b00, 1, 8'd0,   8'd0,   1'b1, 1'b0);
        run_op("div_small",8'd200, 8'd255, 2'b11, W, 8'd0,   8'd200, 1'b0, 1'b0);
        run_op("mul_zero", 8'd0,   8'd77,  2'b10, W, 8'd0,   8'd0,   1'b0, 1'b0);

        // start pulses during EXEC and DONE of a MUL are ignored.
        start_op(8'd25, 8'd13, 2'b10);
        repeat (3) @(negedge clock_i);
        a_i     = 8'd3;
        b_i     = 8'd3;
        fct_i   = 2'b00;
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        wait_done(4, cyc);
        check("ign_latency", cyc, W);
        check("ign_s", s_o, 69);
        check("ign_r", r_o, 1);
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check("ign_done_pulse", done_o, 0);
        check("ign_ready", ready_o, 1);
        @(negedge clock_i);
        check("ign_not_accepted", busy_o, 0);
        check("ign_s_hold", s_o, 69);

        // Reset in the 4th EXEC cycle of a DIV aborts it.
        start_op(8'd100, 8'd7, 2'b11);
        repeat (3) @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        check("abort_ready", ready_o, 1);
        check("abort_done", done_o, 0);
        check("abort_s", s_o, 0);
        check("abort_r", r_o, 0);
        check("abort_carry", carry_o, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clock_i);
            if (done_o === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        run_op("add_after", 8'd1, 8'd1, 2'b00, 1, 8'd2, 8'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_seq_core.md
Name: calc_seq_core

Overview:
Parametrised successor to the calculator control FSM. Operand/function registers, sequencing FSM and an iterative datapath live in one block. It accepts one operation per start/ready handshake and runs ADD/SUB in one execute cycle, or MUL/DIV over WIDTH execute cycles. It returns registered result, remainder/high half, flags and a one-cycle done pulse to the calculator top level.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32); the iteration counter is sized to hold WIDTH.

Ports:
clock_i  in  1  single system clock, rising edge
reset_i  in  1  synchronous reset, active-high
start_i  in  1  request; accepted only on a clock edge where ready_o=1
a_i  in  WIDTH  operand A (unsigned), sampled on accept
b_i  in  WIDTH  operand B (unsigned), sampled on accept
fct_i  in  2  function, sampled on accept: 00 ADD, 01 SUB, 10 MUL, 11 DIV
ready_o  out  1  high in IDLE only
busy_o  out  1  high in EXEC and DONE
done_o  out  1  one-cycle pulse; results valid from this cycle on
s_o  out  WIDTH  result: sum/difference/product low half/quotient
r_o  out  WIDTH  MUL product high half; DIV remainder; 0 for ADD/SUB
carry_o  out  1  ADD carry-out; SUB borrow (a<b); MUL high half nonzero; DIV 0
err_o  out  1  DIV by zero

Behaviour:
- Reset (synchronous, reset_i=1 at an edge): state=IDLE, ready_o=1, busy_o=0, done_o=0, s_o=0, r_o=0, carry_o=0, err_o=0, all internal registers 0. Reset overrides every other event, including mid-EXEC and a simultaneous start_i.
- States: IDLE, EXEC, DONE (two-bit encoding; the unused code returns to IDLE).
- IDLE: on an edge with start_i=1, latch a_i, b_i, fct_i, clear the counter and go to EXEC. Otherwise stay in IDLE.
- start_i in EXEC or DONE is ignored and not queued. Holding start_i high starts a new operation on every return to IDLE.
- EXEC ADD: on the first EXEC edge, s_o=(a+b) mod 2^WIDTH, carry_o=carry-out, r_o=0, err_o=0, then go to DONE.
- EXEC SUB: on the first EXEC edge, s_o=(a-b) mod 2^WIDTH, carry_o=(a<b), r_o=0, err_o=0, then go to DONE.
- EXEC MUL: shift-add, one multiplier bit per edge, LSB first. After WIDTH EXEC edges, {r_o,s_o}=a*b (exact, 2*WIDTH bits), carry_o=|r_o, then go to DONE.
- EXEC DIV: restoring division, one quotient bit per edge, MSB first. After WIDTH EXEC edges, s_o=a/b, r_o=a%b, carry_o=0, then go to DONE.
- DIV with b=0: detected on the first EXEC edge, no iteration. Set s_o=all ones, r_o=a, err_o=1, carry_o=0, then go to DONE.
- Latency with the accept on edge k:
  - ADD/SUB/DIV-by-0: done_o is high in the cycle after edge k+1.
  - MUL/DIV: done_o is high in the cycle after edge k+WIDTH.
  - DONE always lasts one cycle, then IDLE. ready_o rises in the cycle after done_o.
  - Accept-to-accept throughput: 3 cycles for ADD/SUB, WIDTH+2 for MUL/DIV.
- Outputs s_o, r_o, carry_o, err_o update only on the edge entering DONE. They hold until the next operation's DONE edge, or until reset.
- Intermediate iteration values are never visible on the outputs.
- All flags are computed on unsigned operands; there is no signed mode.

Test Plan:
- WIDTH=8, ADD a=200 b=100 → s_o=44, carry_o=1, r_o=0, done_o exactly one cycle, in the cycle after the 2nd edge from accept; ready_o back high the next cycle.
- SUB a=5 b=9 → s_o=252, carry_o=1. SUB a=9 b=5 → s_o=4, carry_o=0.
- MUL a=25 b=13 → s_o=69, r_o=1, carry_o=1, done_o after exactly 8 EXEC cycles. MUL 255*255 → s_o=1, r_o=254.
- DIV a=100 b=7 → s_o=14, r_o=2, err_o=0 after 8 EXEC cycles. DIV a=77 b=0 → s_o=255, r_o=77, err_o=1, done_o with ADD latency.
- Pulse start_i during a MUL, both in EXEC and in DONE → ignored; only one done_o, and the result matches the original operands.
- reset_i=1 on the 4th EXEC cycle of a DIV → next cycle IDLE, ready_o=1, all outputs 0, no done_o. A subsequent ADD 1+1 → s_o=2.
